adder4_seg_display: RTL and testbench



---
 rtl/adder4_disp_pkg.sv | 25 ++
 rtl/adder4_seg_display_seg7_decoder.sv | 21 ++
 rtl/adder4_seg_display.sv | 151 +++++++++++++++
 tb/tb_adder4_seg_display.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder4_disp_pkg.sv
// adder4_disp_pkg: shared constants for the adder result display.
//   SEG_BLANK  - all segments off (active-low {g,f,e,d,c,b,a})
//   SEG_DIGIT  - active-low segment codes for decimal digits 0..9
//   AN_OFF     - all anodes off (active-low)
//   NUM_DIGITS - number of multiplexed digit positions on the board
package adder4_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/adder4_seg_display_seg7_decoder.sv
// seg7_decoder: combinational BCD to active-low 7-segment decoder.
//   bcd - 4-bit BCD digit; codes above 9 produce a blank digit
//   seg - segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import adder4_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup, blanking any non-decimal code.
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGIT[bcd];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/adder4_seg_display.sv
// adder4_seg_display: captures the 4-bit adder result {Cout, Sum} and shows
// it as two decimal digits on a 4-digit multiplexed common-anode display.
//   clk      - system clock, all state on rising edge
//   rst      - synchronous active-high reset
//   in_valid - capture strobe for Sum/Cout
//   Sum      - adder sum bits
//   Cout     - adder carry-out
//   an       - digit anodes, active-low, an[0] rightmost (registered)
//   seg      - segments {g,f,e,d,c,b,a}, active-low (registered)
//   dp       - decimal point, active-low, always off (registered)
module adder4_seg_display
  import adder4_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] Sum,
  input  logic       Cout,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [4:0]       v_q,   v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       an_q,  an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q,  dp_d;

  logic [1:0] tens_s;
  logic [4:0] ones_full_s;
  logic [3:0] ones_s;
  logic [3:0] bcd_sel_s;
  logic [6:0] dec_seg_s;

  // Capture register: the last strobed adder result is held.
  always_comb begin
    v_d = v_q;
    if (in_valid) begin
      v_d = {Cout, Sum};
    end else begin
      v_d = v_q;
    end
  end

  // Refresh divider and digit scan; the index advances only on divider wrap.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q >= CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      idx_d = idx_q;
    end
  end

  // Binary to two-digit BCD split; V never exceeds 31 so tens fits in 2 bits.
  always_comb begin
    tens_s      = 2'd0;
    ones_full_s = v_q;
    if (v_q >= 5'd30) begin
      tens_s      = 2'd3;
      ones_full_s = v_q - 5'd30;
    end else if (v_q >= 5'd20) begin
      tens_s      = 2'd2;
      ones_full_s = v_q - 5'd20;
    end else if (v_q >= 5'd10) begin
      tens_s      = 2'd1;
      ones_full_s = v_q - 5'd10;
    end else begin
      tens_s      = 2'd0;
      ones_full_s = v_q;
    end
  end

  assign ones_s = ones_full_s[3:0];

  // One shared decoder: pick the digit belonging to the current scan slot.
  always_comb begin
    bcd_sel_s = ones_s;
    case (idx_q)
      2'd0:    bcd_sel_s = ones_s;
      2'd1:    bcd_sel_s = {2'b00, tens_s};
      default: bcd_sel_s = ones_s;
    endcase
  end

  seg7_decoder u_dec (
    .bcd (bcd_sel_s),
    .seg (dec_seg_s)
  );

  // Next anode/segment pattern; slots 2 and 3 stay dark, a zero tens digit is blanked.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = dec_seg_s;
      end
      2'd1: begin
        if (tens_s != 2'd0) begin
          an_d  = 4'b1101;
          seg_d = dec_seg_s;
        end else begin
          an_d  = AN_OFF;
          seg_d = SEG_BLANK;
        end
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 5'd0;
      cnt_q <= {CNT_W{1'b0}};
      idx_q <= {IDX_W{1'b0}};
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_adder4_seg_display.sv
// tb_adder4_seg_display: randomized and directed stimulus for the adder result
// display, checked every cycle against a behavioural model, plus literal pins.
module tb_adder4_seg_display;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] Sum;
  logic       Cout;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp  = 0;
  int n_fail = 0;

  adder4_seg_display #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .Sum      (Sum),
    .Cout     (Cout),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent copy of the decimal segment table (active-low {g..a}).
  logic [6:0] ref_code [0:9];
  initial begin
    ref_code[0] = 7'b1000000; ref_code[1] = 7'b1111001;
    ref_code[2] = 7'b0100100; ref_code[3] = 7'b0110000;
    ref_code[4] = 7'b0011001; ref_code[5] = 7'b0010010;
    ref_code[6] = 7'b0000010; ref_code[7] = 7'b1111000;
    ref_code[8] = 7'b0000000; ref_code[9] = 7'b0010000;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model and per-cycle compare: t counts cycles since reset, V the held value.
  initial begin : model
    int  mv;
    int  t;
    bit  armed;
    int  slot;
    int  exp_an;
    int  exp_seg;
    bit  s_rst;
    bit  s_iv;
    int  s_val;
    armed   = 1'b0;
    mv      = 0;
    t       = 0;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_iv  = in_valid;
      s_val = {27'd0, Cout, Sum};
      if (s_rst) begin
        armed   = 1'b1;
        mv      = 0;
        t       = 0;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else if (armed) begin
        slot = (t / DIV) % 4;
        if (slot == 0) begin
          exp_an  = 4'b1110;
          exp_seg = ref_code[mv % 10];
        end else if (slot == 1 && (mv / 10) != 0) begin
          exp_an  = 4'b1101;
          exp_seg = ref_code[mv / 10];
        end else begin
          exp_an  = 4'hF;
          exp_seg = 7'h7F;
        end
        if (s_iv) mv = s_val;
        t++;
      end
      #1;
      if (armed) begin
        check("model_an", an, exp_an);
        check("model_seg", seg, exp_seg);
        check("model_dp", dp, 1);
        check("an_not_multi_hot", ($countones(~an) <= 1) ? 1 : 0, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [3:0] s, input logic c);
    Sum      = s;
    Cout     = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  // Bounded wait until the given anode pattern is shown.
  task automatic wait_an(input string name, input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * DIV * 2 + 2; i++) begin
      if (an == target) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(name, found, 1);
  endtask

  initial begin : stim
    int lit;
    rst      = 1'b1;
    in_valid = 1'b0;
    Sum      = 4'd0;
    Cout     = 1'b0;
    tick();
    tick();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", dp, 1);
    rst = 1'b0;
    tick();
    check("rel_an", an, 4'b1110);
    check("rel_seg", seg, 7'b1000000);

    // 6 + 10 = 16
    capture(4'b0000, 1'b1);
    wait_an("v16_wait_ones", 4'b1110);
    check("v16_ones", seg, 7'b0000010);
    wait_an("v16_wait_tens", 4'b1101);
    check("v16_tens", seg, 7'b1111001);

    // 2 + 7 = 9: tens slot must stay dark for a full scan
    capture(4'b1001, 1'b0);
    wait_an("v9_wait_ones", 4'b1110);
    check("v9_ones", seg, 7'b0010000);
    lit = 0;
    for (int i = 0; i < 4 * DIV * 2; i++) begin
      if (an == 4'b1101) lit++;
      tick();
    end
    check("v9_tens_blank", lit, 0);

    // 12, 8, 13, one capture every 8 scan slots
    capture(4'b1100, 1'b0);
    repeat (8 * DIV - 3) tick();
    capture(4'b1000, 1'b0);
    repeat (8 * DIV - 3) tick();
    capture(4'b1101, 1'b0);
    wait_an("v13_wait_tens", 4'b1101);
    check("v13_tens", seg, 7'b1111001);
    wait_an("v13_wait_ones", 4'b1110);
    check("v13_ones", seg, 7'b0110000);
    repeat (8 * DIV - 6) tick();

    // Maximum value 31, then reset in the middle of a slot
    capture(4'b1111, 1'b1);
    wait_an("v31_wait_tens", 4'b1101);
    check("v31_tens", seg, 7'b0110000);
    wait_an("v31_wait_ones", 4'b1110);
    check("v31_ones", seg, 7'b1111001);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_an", an, 4'b1111);
    check("midrst_seg", seg, 7'b1111111);
    rst = 1'b0;
    tick();
    check("midrst_rel_an", an, 4'b1110);
    check("midrst_rel_seg", seg, 7'b1000000);

    // Random captures with occasional resets; the model checks every cycle
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      Sum      = 4'($urandom);
      Cout     = 1'($urandom);
      rst      = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (4 * DIV) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
